// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder
// Brief    : Single-port word memory behind valid/ready request/response
//            channels, with configurable wait states and error flagging.
// Revision : 1.0 - initial release
// ============================================================================

module mem_responder #(
   parameter int          DEPTH_WORDS = 1024,
   parameter int          LATENCY     = 1,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [31:0] req_addr_i,
   input  logic        req_we_i,
   input  logic [31:0] req_wdata_i,
   input  logic [3:0]  req_be_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_rdata_o,
   output logic        rsp_err_o
);

   localparam int AW = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [3:0]  count;
   logic [3:0]  count_next;
   logic        do_access;

   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic        we_q;
   logic [3:0]  be_q;

   logic        accept;
   logic        use_live;
   logic [31:0] acc_addr;
   logic [31:0] acc_wdata;
   logic        acc_we;
   logic [3:0]  acc_be;
   logic [31:0] offset;
   logic        acc_err;
   logic [AW-1:0] index;

   logic [31:0] mem [DEPTH_WORDS];

   assign req_ready_o = (state == IDLE) && !reset_i;
   assign accept      = req_valid_i && req_ready_o;
   assign rsp_valid_o = (state == RESP);

   // With zero wait states the access happens on the accept edge itself,
   // so it must use the live request rather than the latched copy.
   assign use_live  = (state == IDLE);
   assign acc_addr  = use_live ? req_addr_i  : addr_q;
   assign acc_wdata = use_live ? req_wdata_i : wdata_q;
   assign acc_we    = use_live ? req_we_i    : we_q;
   assign acc_be    = use_live ? req_be_i    : be_q;

   // Unsigned wrap makes addresses below BASE_ADDR land out of range.
   assign offset  = acc_addr - BASE_ADDR;
   assign acc_err = (acc_addr[1:0] != 2'b00) || ((offset >> 2) >= 32'(DEPTH_WORDS));
   assign index   = offset[AW+1:2];

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state <= IDLE;
         count <= 4'd0;
      end else begin
         state <= state_next;
         count <= count_next;
      end
   end

   always_comb begin
      state_next = state;
      count_next = count;
      do_access  = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               if (LATENCY == 0) begin
                  state_next = RESP;
                  do_access  = 1'b1;
               end else begin
                  state_next = WAIT;
                  count_next = 4'(LATENCY - 1);
               end
            end
         end
         WAIT: begin
            if (count == 4'd0) begin
               state_next = RESP;
               do_access  = 1'b1;
            end else begin
               count_next = count - 4'd1;
            end
         end
         RESP: begin
            if (rsp_ready_i) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (accept) begin
         addr_q  <= req_addr_i;
         wdata_q <= req_wdata_i;
         we_q    <= req_we_i;
         be_q    <= req_be_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         rsp_rdata_o <= 32'd0;
         rsp_err_o   <= 1'b0;
      end else if (do_access) begin
         rsp_err_o   <= acc_err;
         rsp_rdata_o <= (acc_err || acc_we) ? 32'd0 : mem[index];
      end
   end

   // Backing store is never reset; a write pending in WAIT dies with reset.
   always_ff @(posedge clk_i) begin
      if (do_access && !reset_i && acc_we && !acc_err) begin
         for (int b = 0; b < 4; b++) begin
            if (acc_be[b]) begin
               mem[index][8*b +: 8] <= acc_wdata[8*b +: 8];
            end
         end
      end
   end

endmodule

`default_nettype wire
